// File: rtl/ser_if.sv
// +--------------------------------------------------------------------+
// | ser_if : byte-wide register bus between the bus controller and ser  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

interface ser_if;
  logic       en;
  logic       wr;
  logic [3:2] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       wt;

  modport master (output en, wr, addr, data_in, input data_out, wt);
  modport slave  (input en, wr, addr, data_in, output data_out, wt);
endinterface

`default_nettype wire

// File: rtl/ser.sv
// +--------------------------------------------------------------------+
// | ser : memory-mapped 8N1 UART with rx/tx level interrupts            |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module ser #(
  parameter int BAUD_DIV = 434
) (
  input  logic clk,
  input  logic reset,
  ser_if.slave bus,
  output logic irq_r,
  output logic irq_t,
  input  logic rxd,
  output logic txd
);

  localparam logic [15:0] c_bit_reload = 16'(BAUD_DIV - 1);
  localparam logic [15:0] c_half_bit   = 16'(BAUD_DIV / 2);

  localparam logic [1:0] c_tx_idle  = 2'd0;
  localparam logic [1:0] c_tx_start = 2'd1;
  localparam logic [1:0] c_tx_data  = 2'd2;
  localparam logic [1:0] c_tx_stop  = 2'd3;

  localparam logic [2:0] c_rx_idle   = 3'd0;
  localparam logic [2:0] c_rx_start  = 3'd1;
  localparam logic [2:0] c_rx_data   = 3'd2;
  localparam logic [2:0] c_rx_stop   = 3'd3;
  localparam logic [2:0] c_rx_waithi = 3'd4;

  // ---------------- bus side ----------------
  logic       r_ack;
  logic [7:0] r_data_out;
  logic       r_rx_ien, r_tx_ien;
  logic       r_rx_rdy, r_tx_rdy, r_ovr;
  logic [7:0] r_rx_buf;
  logic       w_acc, w_rd, w_wr, w_rd_rdata, w_tx_load, w_rx_done;
  logic [7:0] w_rd_mux;

  // Side effects happen only on the edge where ack rises.
  assign w_acc      = bus.en & ~r_ack;
  assign w_rd       = w_acc & ~bus.wr;
  assign w_wr       = w_acc & bus.wr;
  assign w_rd_rdata = w_rd & (bus.addr == 2'd1);
  assign w_tx_load  = w_wr & (bus.addr == 2'd3) & r_tx_rdy;

  assign bus.wt       = w_acc;
  assign bus.data_out = r_data_out;
  assign irq_r        = r_rx_rdy & r_rx_ien;
  assign irq_t        = r_tx_rdy & r_tx_ien;

  always_comb begin
    w_rd_mux = 8'h00;
    case (bus.addr)
      2'd0:    w_rd_mux = {5'b0, r_ovr, r_rx_ien, r_rx_rdy};
      2'd1:    w_rd_mux = r_rx_buf;
      2'd2:    w_rd_mux = {6'b0, r_tx_ien, r_tx_rdy};
      default: w_rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ack      <= 1'b0;
      r_data_out <= 8'h00;
      r_rx_ien   <= 1'b0;
      r_tx_ien   <= 1'b0;
    end else begin
      r_ack <= w_acc;
      if (w_rd)
        r_data_out <= w_rd_mux;
      if (w_wr && bus.addr == 2'd0)
        r_rx_ien <= bus.data_in[1];
      if (w_wr && bus.addr == 2'd2)
        r_tx_ien <= bus.data_in[1];
    end
  end

  // ---------------- transmitter ----------------
  logic [1:0]  r_tx_state, w_tx_next;
  logic [15:0] r_tx_cnt;
  logic [2:0]  r_tx_bit;
  logic [7:0]  r_tx_shift;
  logic        r_txd, w_txd;
  logic        w_tx_exp;

  assign w_tx_exp = (r_tx_cnt == 16'd0);
  assign txd      = r_txd;

  always_ff @(posedge clk) begin
    if (reset) r_tx_state <= c_tx_idle;
    else       r_tx_state <= w_tx_next;
  end

  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      c_tx_idle:  if (w_tx_load) w_tx_next = c_tx_start;
      c_tx_start: if (w_tx_exp) w_tx_next = c_tx_data;
      c_tx_data:  if (w_tx_exp && r_tx_bit == 3'd7) w_tx_next = c_tx_stop;
      c_tx_stop:  if (w_tx_exp) w_tx_next = c_tx_idle;
      default:    w_tx_next = c_tx_idle;
    endcase
  end

  always_comb begin
    w_txd = 1'b1;
    case (r_tx_state)
      c_tx_start: w_txd = 1'b0;
      c_tx_data:  w_txd = r_tx_shift[0];
      default:    w_txd = 1'b1;
    endcase
  end

  // txd is re-registered so the line drops one edge after the accepting write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_txd      <= 1'b1;
      r_tx_cnt   <= 16'd0;
      r_tx_bit   <= 3'd0;
      r_tx_shift <= 8'h00;
      r_tx_rdy   <= 1'b1;
    end else begin
      r_txd <= w_txd;
      if (w_tx_load) begin
        r_tx_shift <= bus.data_in;
        r_tx_cnt   <= c_bit_reload;
        r_tx_bit   <= 3'd0;
        r_tx_rdy   <= 1'b0;
      end else if (r_tx_state != c_tx_idle) begin
        if (w_tx_exp) begin
          r_tx_cnt <= c_bit_reload;
          if (r_tx_state == c_tx_data) begin
            r_tx_shift <= r_tx_shift >> 1;
            r_tx_bit   <= r_tx_bit + 3'd1;
          end
          if (r_tx_state == c_tx_stop)
            r_tx_rdy <= 1'b1;
        end else begin
          r_tx_cnt <= r_tx_cnt - 16'd1;
        end
      end
    end
  end

  // ---------------- receiver ----------------
  logic        r_rx_s1, r_rx_s2;
  logic [2:0]  r_rx_state, w_rx_next;
  logic [15:0] r_rx_cnt;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_shift;
  logic        w_rx_exp;

  assign w_rx_exp  = (r_rx_cnt == 16'd0);
  assign w_rx_done = (r_rx_state == c_rx_stop) & w_rx_exp & r_rx_s2;

  always_ff @(posedge clk) begin
    if (reset) r_rx_state <= c_rx_idle;
    else       r_rx_state <= w_rx_next;
  end

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      c_rx_idle:   if (!r_rx_s2) w_rx_next = c_rx_start;
      c_rx_start:  if (w_rx_exp) w_rx_next = r_rx_s2 ? c_rx_idle : c_rx_data;
      c_rx_data:   if (w_rx_exp && r_rx_bit == 3'd7) w_rx_next = c_rx_stop;
      c_rx_stop:   if (w_rx_exp) w_rx_next = r_rx_s2 ? c_rx_idle : c_rx_waithi;
      c_rx_waithi: if (r_rx_s2) w_rx_next = c_rx_idle;
      default:     w_rx_next = c_rx_idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_cnt   <= 16'd0;
      r_rx_bit   <= 3'd0;
      r_rx_shift <= 8'h00;
      r_rx_buf   <= 8'h00;
      r_rx_rdy   <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      r_rx_s1 <= rxd;
      r_rx_s2 <= r_rx_s1;
      case (r_rx_state)
        c_rx_idle: begin
          r_rx_cnt <= c_half_bit;
          r_rx_bit <= 3'd0;
        end
        c_rx_start, c_rx_data, c_rx_stop: begin
          if (w_rx_exp) begin
            r_rx_cnt <= c_bit_reload;
            if (r_rx_state == c_rx_data) begin
              r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
              r_rx_bit   <= r_rx_bit + 3'd1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt - 16'd1;
          end
        end
        default: r_rx_cnt <= 16'd0;
      endcase
      // A completing byte beats a same-edge data read; the read still sees the old buffer.
      if (w_rx_done) begin
        r_rx_buf <= r_rx_shift;
        r_rx_rdy <= 1'b1;
        r_ovr    <= w_rd_rdata ? 1'b0 : r_rx_rdy;
      end else if (w_rd_rdata) begin
        r_rx_rdy <= 1'b0;
        r_ovr    <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/ser.md
# ser

Memory-mapped 8N1 UART serving one serial channel; two instances (ser0, ser1) sit directly downstream of the bus controller in the I/O window at 0x3030_0000 and 0x3030_1000. It presents four byte-wide registers to the bus on a one-wait-state handshake, serialises transmit bytes onto `txd`, deserialises `rxd`, and raises level interrupts for "byte received" and "transmitter ready".

## Interface
- `BAUD_DIV`, 434, clock cycles per bit time (50 MHz / 115200); legal range 4..65535.

- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  1  bus select from bus controller.
- `wr`  in  1  1 = write, 0 = read; valid while `en`.
- `addr`  in  [3:2]  register select: 0 rcv ctrl, 1 rcv data, 2 xmt ctrl, 3 xmt data.
- `data_in`  in  8  write data.
- `data_out`  out  8  read data, valid when `en` and not `wt`.
- `wt`  out  1  wait request to bus.
- `irq_r`  out  1  receive interrupt.
- `irq_t`  out  1  transmit interrupt.
- `rxd`  in  1  serial input, asynchronous.
- `txd`  out  1  serial output, idle high.

## Operation
- Bus handshake: internal `ack` flop; `wt = en & ~ack`; `ack <= en & ~ack`. Register side effects and `data_out` capture occur on the edge where `ack` goes 1. `en` held continuously yields one completed access every 2 cycles.
- Rcv ctrl read: {5'b0, ovr, r_ien, r_rdy}. Write: r_ien <= data_in[1]; other bits read-only.
- Rcv data read: returns rx buffer; clears r_rdy and ovr. Write ignored.
- Xmt ctrl read: {6'b0, t_ien, t_rdy}. Write: t_ien <= data_in[1].
- Xmt data write: if t_rdy=1, load shifter, t_rdy <= 0, start frame; if t_rdy=0, write dropped. Read returns 0.
- `irq_r = r_rdy & r_ien`, `irq_t = t_rdy & t_ien`, both registered-state combinational.
- Transmitter states IDLE, START, DATA(8, LSB first), STOP. Each bit held exactly BAUD_DIV cycles. t_rdy returns to 1 on the edge ending the stop bit.
- Receiver: `rxd` passes a 2-flop synchroniser. States IDLE, START, DATA, STOP, WAITHI.
  - IDLE: synced rxd=0 -> START, counter = BAUD_DIV/2 (truncating).
  - START: at count expiry resample; 1 -> IDLE (glitch), 0 -> DATA.
  - DATA: sample every BAUD_DIV cycles, 8 samples, LSB first.
  - STOP: sample after BAUD_DIV; 1 -> write buffer, r_rdy <= 1, ovr <= r_rdy (old value), -> IDLE; 0 -> byte discarded, -> WAITHI.
  - WAITHI: stay until synced rxd=1, then IDLE.
- Simultaneous byte completion and rcv-data read on same edge: new byte wins, r_rdy stays 1, ovr cleared, read returns old buffer.
- Overrun: new byte overwrites buffer, r_rdy stays 1, ovr set.

## Timing
- Reset values: `txd`=1, `data_out`=0, `ack`=0 (so `wt`=`en`), t_rdy=1, r_rdy=0, ovr=0, both ien=0, `irq_r`=`irq_t`=0, both FSMs IDLE, counters 0.
- Reset mid-frame: frame aborted; `txd`=1 after the reset edge; partial rx byte discarded.
- Read latency: `data_out` valid in cycle after first `en` cycle.
- TX: `txd` falls on the edge after the accepting write edge; frame occupies 10·BAUD_DIV cycles; t_rdy rises at write edge + 10·BAUD_DIV.
- RX: r_rdy rises 2 (sync) + BAUD_DIV/2 + 9·BAUD_DIV (±1) cycles after the falling start edge at `rxd`.
- Bit counters 16 bits, reload BAUD_DIV-1, expire at 0.

## Test plan
- Reset with BAUD_DIV=16: `txd`=1, xmt ctrl reads 0x01, rcv ctrl reads 0x00, `wt` equals `en` for one cycle, both irq 0.
- Write 0xA5 to xmt data: `txd` sequence 0,1,0,1,0,0,1,0,1,1 each 16 cycles; t_rdy 0 for 160 cycles; second write during frame dropped.
- Drive 0x3C frame on `rxd`: rcv ctrl reads 0x01; with r_ien=1 `irq_r`=1; rcv data read returns 0x3C and clears `irq_r`.
- Two frames 0x11, 0x22 without reading: rcv ctrl 0x05, data 0x22, ctrl then 0x00.
- 4-cycle low glitch on `rxd`: no r_rdy; stop bit forced 0: byte discarded, next valid frame accepted only after `rxd` high.
- Assert `reset` at bit 4 of transmit: `txd`=1 next cycle, xmt ctrl reads 0x01.
